// File: rtl/seq_pattern_detector_fsm_if.sv
// Serial-detector bus: sample strobe, clear and data in; prefix state, hits and count out.
`timescale 1ns/1ps
interface seq_pattern_detector_fsm_if #(
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 8
);
  localparam int SW = $clog2(PAT_LEN + 1);

  logic             en;
  logic             clr;
  logic             din;
  logic [SW-1:0]    tt_ht;
  logic             hit_moore;
  logic             hit_mealy;
  logic [CNT_W-1:0] match_cnt;

  modport master (
    output en, clr, din,
    input  tt_ht, hit_moore, hit_mealy, match_cnt
  );

  modport slave (
    input  en, clr, din,
    output tt_ht, hit_moore, hit_mealy, match_cnt
  );
endinterface

// File: rtl/seq_pattern_detector_fsm.sv
// Parametrised serial pattern detector with Moore and Mealy hit outputs.
// Optional saturating match counter enabled by SEQ_PATTERN_DETECTOR_MATCH_COUNT_EN.
`timescale 1ns/1ps
module seq_pattern_detector_fsm #(
  parameter int               PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter int               OVERLAP = 1,
  parameter int               CNT_W   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  seq_pattern_detector_fsm_if.slave bus
);

  localparam int SW = $clog2(PAT_LEN + 1);
  localparam int NS = 1 << SW;

  typedef logic [SW-1:0] state_t;

  localparam state_t FULL = state_t'(PAT_LEN);

  if (PAT_LEN < 2 || PAT_LEN > 16) begin : g_bad_len
    $error("seq_pattern_detector_fsm: PAT_LEN must be 2..16");
  end

  function automatic logic pat_bit(input int i);
    logic [PAT_LEN-1:0] t;
    t = PATTERN >> i;
    return t[0];
  endfunction

  // Longest pattern prefix that is a suffix of (first k pattern bits, then b).
  function automatic int next_prefix(input int k, input logic b);
    int   best;
    int   idx;
    logic ok;
    logic s_bit;
    best = 0;
    if (k <= PAT_LEN) begin
      for (int j = 1; j <= PAT_LEN; j++) begin
        if (j <= k + 1) begin
          ok = 1'b1;
          for (int m = 0; m < j; m++) begin
            idx   = k + 1 - j + m;
            s_bit = (idx == k) ? b : pat_bit(PAT_LEN - 1 - idx);
            if (s_bit != pat_bit(PAT_LEN - 1 - m)) begin
              ok = 1'b0;
            end
          end
          if (ok) begin
            best = j;
          end
        end
      end
    end
    return best;
  endfunction

  state_t nx0_s [NS];
  state_t nx1_s [NS];

  // Unused encodings above PAT_LEN fall back to S0.
  for (genvar k = 0; k < NS; k++) begin : g_tab
    localparam int     KE = (k == PAT_LEN && OVERLAP == 0) ? 0 : k;
    localparam state_t N0 = state_t'(next_prefix(KE, 1'b0));
    localparam state_t N1 = state_t'(next_prefix(KE, 1'b1));
    assign nx0_s[k] = N0;
    assign nx1_s[k] = N1;
  end

  state_t tt_ht_q;
  state_t tt_ht_d;
  state_t tt_kt_s;
  logic   hit_moore_q;
  logic   hit_moore_d;
  logic   hit_mealy_s;

  // Next-state lookup, Mealy hit and registered-output next values.
  always_comb begin
    tt_kt_s     = bus.din ? nx1_s[tt_ht_q] : nx0_s[tt_ht_q];
    hit_mealy_s = bus.en & ~bus.clr & ~reset & (tt_kt_s == FULL);
    if (bus.clr) begin
      tt_ht_d = {SW{1'b0}};
    end else if (bus.en) begin
      tt_ht_d = tt_kt_s;
    end else begin
      tt_ht_d = tt_ht_q;
    end
    hit_moore_d = (tt_ht_d == FULL);
  end

  // Prefix-length state and registered Moore hit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tt_ht_q     <= {SW{1'b0}};
      hit_moore_q <= 1'b0;
    end else begin
      tt_ht_q     <= tt_ht_d;
      hit_moore_q <= hit_moore_d;
    end
  end

  assign bus.tt_ht     = tt_ht_q;
  assign bus.hit_moore = hit_moore_q;
  assign bus.hit_mealy = hit_mealy_s;

`ifdef SEQ_PATTERN_DETECTOR_MATCH_COUNT_EN
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Saturating counter; clear wins over a coincident hit.
  always_comb begin
    if (bus.clr) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (hit_mealy_s && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Match counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.match_cnt = cnt_q;
`else
  assign bus.match_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_seq_pattern_detector_fsm.sv
// Self-checking bench: four detector configurations driven by one serial stream,
// checked against a history-matching reference model and hand-written expectations.
`timescale 1ns/1ps
module tb_seq_pattern_detector_fsm;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en_s = 1'b0;
  logic clr_s = 1'b0;
  logic din_s = 1'b0;

  always #5 clk = ~clk;

  seq_pattern_detector_fsm_if #(.PAT_LEN(4), .CNT_W(8)) if_a ();
  seq_pattern_detector_fsm_if #(.PAT_LEN(4), .CNT_W(8)) if_b ();
  seq_pattern_detector_fsm_if #(.PAT_LEN(4), .CNT_W(8)) if_c ();
  seq_pattern_detector_fsm_if #(.PAT_LEN(4), .CNT_W(2)) if_d ();

  assign if_a.en = en_s;  assign if_a.clr = clr_s;  assign if_a.din = din_s;
  assign if_b.en = en_s;  assign if_b.clr = clr_s;  assign if_b.din = din_s;
  assign if_c.en = en_s;  assign if_c.clr = clr_s;  assign if_c.din = din_s;
  assign if_d.en = en_s;  assign if_d.clr = clr_s;  assign if_d.din = din_s;

  seq_pattern_detector_fsm #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(8))
    u_a (.clk(clk), .reset(reset), .bus(if_a));
  seq_pattern_detector_fsm #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(0), .CNT_W(8))
    u_b (.clk(clk), .reset(reset), .bus(if_b));
  seq_pattern_detector_fsm #(.PAT_LEN(4), .PATTERN(4'b1111), .OVERLAP(1), .CNT_W(8))
    u_c (.clk(clk), .reset(reset), .bus(if_c));
  seq_pattern_detector_fsm #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(2))
    u_d (.clk(clk), .reset(reset), .bus(if_d));

  logic [2:0] tt_o    [4];
  logic       moore_o [4];
  logic       mealy_o [4];
  logic [7:0] cnt_o   [4];

  assign tt_o[0] = if_a.tt_ht;  assign moore_o[0] = if_a.hit_moore;
  assign tt_o[1] = if_b.tt_ht;  assign moore_o[1] = if_b.hit_moore;
  assign tt_o[2] = if_c.tt_ht;  assign moore_o[2] = if_c.hit_moore;
  assign tt_o[3] = if_d.tt_ht;  assign moore_o[3] = if_d.hit_moore;
  assign mealy_o[0] = if_a.hit_mealy;  assign cnt_o[0] = if_a.match_cnt;
  assign mealy_o[1] = if_b.hit_mealy;  assign cnt_o[1] = if_b.match_cnt;
  assign mealy_o[2] = if_c.hit_mealy;  assign cnt_o[2] = if_c.match_cnt;
  assign mealy_o[3] = if_d.hit_mealy;  assign cnt_o[3] = {6'b000000, if_d.match_cnt};

  // Reference model: keeps the raw bit history and searches it for the pattern.
  logic [3:0]  pat_m  [4] = '{4'b1011, 4'b1011, 4'b1111, 4'b1011};
  bit          ov_m   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  int          cmax_m [4] = '{255, 255, 255, 3};
  logic [31:0] hist_m [4];
  int          hl_m   [4];
  int          tt_m   [4];
  int          cnt_m  [4];
  bit          mealy_m[4];

  typedef struct {
    int dut;
    int tt;
    bit moore;
    int cnt;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    bit en;
    bit clr;
    bit din;
    int tt_a;
    bit mealy_a;
    int tt_b;
    bit mealy_b;
  } vec_t;
  vec_t tab[7];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 4; d++) begin
      hist_m[d] = 32'd0; hl_m[d] = 0; tt_m[d] = 0; cnt_m[d] = 0; mealy_m[d] = 1'b0;
    end
  endtask

  function automatic bit hist_match(input int d, input int len);
    logic [31:0] h;
    logic [31:0] p;
    bit ok;
    ok = 1'b1;
    for (int m = 0; m < len; m++) begin
      h = hist_m[d] >> (len - 1 - m);
      p = {28'd0, pat_m[d]} >> (3 - m);
      if (h[0] != p[0]) ok = 1'b0;
    end
    return ok;
  endfunction

  task automatic model_step(input bit en, input bit clr, input bit din);
    int j;
    for (int d = 0; d < 4; d++) begin
      if (clr) begin
        hist_m[d] = 32'd0; hl_m[d] = 0; tt_m[d] = 0; cnt_m[d] = 0; mealy_m[d] = 1'b0;
      end else if (en) begin
        if (!ov_m[d] && tt_m[d] == 4) hl_m[d] = 0;
        hist_m[d] = {hist_m[d][30:0], din};
        hl_m[d]++;
        j = 0;
        for (int len = 1; len <= 4; len++) begin
          if (len <= hl_m[d] && hist_match(d, len)) j = len;
        end
        tt_m[d]    = j;
        mealy_m[d] = (j == 4);
`ifdef SEQ_PATTERN_DETECTOR_MATCH_COUNT_EN
        if (mealy_m[d] && cnt_m[d] < cmax_m[d]) cnt_m[d]++;
`endif
      end else begin
        mealy_m[d] = 1'b0;
      end
    end
  endtask

  // One clock: drive at negedge, check Mealy mid-cycle, check registered outputs after the edge.
  task automatic step(input bit en, input bit clr, input bit din, output logic [3:0] mealy_seen);
    exp_t e;
    @(negedge clk);
    en_s = en; clr_s = clr; din_s = din;
    model_step(en, clr, din);
    #1;
    for (int d = 0; d < 4; d++) begin
      mealy_seen[d] = mealy_o[d];
      check($sformatf("hit_mealy[%0d]", d), int'(mealy_o[d]), int'(mealy_m[d]));
      e.dut = d; e.tt = tt_m[d]; e.moore = (tt_m[d] == 4); e.cnt = cnt_m[d];
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check($sformatf("tt_ht[%0d]", e.dut), int'(tt_o[e.dut]), e.tt);
      check($sformatf("hit_moore[%0d]", e.dut), int'(moore_o[e.dut]), int'(e.moore));
      check($sformatf("match_cnt[%0d]", e.dut), int'(cnt_o[e.dut]), e.cnt);
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int d = 0; d < 4; d++) begin
      check($sformatf("%s tt_ht[%0d]", tag, d), int'(tt_o[d]), 0);
      check($sformatf("%s hit_moore[%0d]", tag, d), int'(moore_o[d]), 0);
      check($sformatf("%s hit_mealy[%0d]", tag, d), int'(mealy_o[d]), 0);
      check($sformatf("%s match_cnt[%0d]", tag, d), int'(cnt_o[d]), 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ms;
    int hits_a;
    int hits_c;
    int moore_c;
    int cnt_exp;

    tab[0] = '{1'b1, 1'b0, 1'b1, 1, 1'b0, 1, 1'b0};
    tab[1] = '{1'b1, 1'b0, 1'b0, 2, 1'b0, 2, 1'b0};
    tab[2] = '{1'b1, 1'b0, 1'b1, 3, 1'b0, 3, 1'b0};
    tab[3] = '{1'b1, 1'b0, 1'b1, 4, 1'b1, 4, 1'b1};
    tab[4] = '{1'b1, 1'b0, 1'b0, 2, 1'b0, 0, 1'b0};
    tab[5] = '{1'b1, 1'b0, 1'b1, 3, 1'b0, 1, 1'b0};
    tab[6] = '{1'b1, 1'b0, 1'b1, 4, 1'b1, 1, 1'b0};

    model_reset();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    // 1011 stream in overlap (A) and restart (B) modes.
    for (int i = 0; i < 7; i++) begin
      step(tab[i].en, tab[i].clr, tab[i].din, ms);
      check($sformatf("tab%0d mealy_a", i), int'(ms[0]), int'(tab[i].mealy_a));
      check($sformatf("tab%0d mealy_b", i), int'(ms[1]), int'(tab[i].mealy_b));
      check($sformatf("tab%0d tt_a", i), int'(tt_o[0]), tab[i].tt_a);
      check($sformatf("tab%0d tt_b", i), int'(tt_o[1]), tab[i].tt_b);
    end

    // Six 1s into the self-overlapping 1111 detector.
    step(1'b1, 1'b1, 1'b0, ms);
    hits_c = 0; moore_c = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 1'b1, ms);
      if (ms[2]) hits_c++;
      if (moore_o[2]) moore_c++;
    end
    check("ones hits_c", hits_c, 3);
    check("ones moore_cycles_c", moore_c, 3);
`ifdef SEQ_PATTERN_DETECTOR_MATCH_COUNT_EN
    cnt_exp = 3;
`else
    cnt_exp = 0;
`endif
    check("ones match_cnt_c", int'(cnt_o[2]), cnt_exp);

    // Five overlapping 1011 matches: 2-bit counter saturates, then clear.
    step(1'b1, 1'b1, 1'b0, ms);
    hits_a = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, ((i % 3) != 1) ? 1'b1 : 1'b0, ms);
      if (ms[0]) hits_a++;
    end
    check("sat hits_a", hits_a, 5);
`ifdef SEQ_PATTERN_DETECTOR_MATCH_COUNT_EN
    cnt_exp = 3;
`else
    cnt_exp = 0;
`endif
    check("sat match_cnt_d", int'(cnt_o[3]), cnt_exp);
    step(1'b1, 1'b1, 1'b0, ms);
    check("sat clr match_cnt_d", int'(cnt_o[3]), 0);

    // Hold with en=0 and toggling din, then complete the match.
    step(1'b1, 1'b0, 1'b1, ms);
    step(1'b1, 1'b0, 1'b0, ms);
    step(1'b1, 1'b0, 1'b1, ms);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, (i % 2 == 0) ? 1'b1 : 1'b0, ms);
      check($sformatf("hold%0d tt_a", i), int'(tt_o[0]), 3);
      check($sformatf("hold%0d mealy_a", i), int'(ms[0]), 0);
    end
    step(1'b1, 1'b0, 1'b1, ms);
    check("hold release mealy_a", int'(ms[0]), 1);

    // Clear coincident with what would be a hit.
    step(1'b1, 1'b0, 1'b0, ms);
    step(1'b1, 1'b0, 1'b1, ms);
    check("pre-clr tt_a", int'(tt_o[0]), 3);
    step(1'b1, 1'b1, 1'b1, ms);
    check("clr-hit mealy_a", int'(ms[0]), 0);
    check("clr-hit tt_a", int'(tt_o[0]), 0);
    check("clr-hit match_cnt_a", int'(cnt_o[0]), 0);

    // Asynchronous reset between edges mid-sequence.
    step(1'b1, 1'b0, 1'b1, ms);
    step(1'b1, 1'b0, 1'b0, ms);
    step(1'b1, 1'b0, 1'b1, ms);
    @(negedge clk);
    en_s = 1'b1; clr_s = 1'b0; din_s = 1'b1;
    #1;
    check("pre-reset mealy_a", int'(mealy_o[0]), 1);
    #1;
    reset = 1'b1;
    #1;
    check_all_zero("async reset");
    model_reset();
    en_s = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    hits_a = 0;
    step(1'b1, 1'b0, 1'b1, ms); if (ms[0]) hits_a++;
    step(1'b1, 1'b0, 1'b0, ms); if (ms[0]) hits_a++;
    step(1'b1, 1'b0, 1'b1, ms); if (ms[0]) hits_a++;
    step(1'b1, 1'b0, 1'b1, ms); if (ms[0]) hits_a++;
    check("post-reset hits_a", hits_a, 1);
    check("post-reset tt_a", int'(tt_o[0]), 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
